// File: rtl/psum_requant_pkg.sv
// Shared constants, job configuration record and FSM state encoding for the
// partial-sum requantizer.
package psum_requant_pkg;

  localparam int PSUM_WIDTH    = 32;
  localparam int DEF_ACC_WIDTH = 40;
  localparam int DEF_OUT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0]  num_chunks;
    logic [15:0] num_outputs;
    logic [15:0] scale;
    logic [4:0]  shift;
    logic        relu_en;
  } rq_cfg_t;

  // A zero count means "one", so the per-job counters always have a target.
  function automatic logic [15:0] at_least_one(input logic [15:0] n);
    return (n == 16'd0) ? 16'd1 : n;
  endfunction

endpackage

// File: rtl/psum_requant_if.sv
// Downstream result stream. Valid/ready: a word moves when o_valid and i_ready
// are both high on a rising edge; o_data/o_last hold while o_valid waits.
interface psum_requant_if #(
  parameter int OUT_WIDTH = psum_requant_pkg::DEF_OUT_WIDTH
);
  logic                        o_valid;
  logic                        i_ready;
  logic signed [OUT_WIDTH-1:0] o_data;
  logic                        o_last;

  modport master (output o_valid, output o_data, output o_last, input i_ready);
  modport slave  (input o_valid, input o_data, input o_last, output i_ready);
endinterface

// File: rtl/psum_out_fifo.sv
// Show-ahead result FIFO. A write into a full FIFO is dropped (ovf pulses)
// unless a read in the same cycle frees a slot.
module psum_out_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             ovf,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, rd_ok, wr_ok;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);
  assign ovf   = wr_en && !wr_ok;
  // Zero while empty so the output reads as 0 after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/psum_requant.sv
// Accumulates partial sums per output, requantizes (multiply, rounding shift,
// optional ReLU, saturate) over two pipeline stages and queues results.
module psum_requant
  import psum_requant_pkg::*;
#(
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  input  logic [7:0]                   i_num_chunks,
  input  logic [15:0]                  i_num_outputs,
  input  logic [15:0]                  i_scale,
  input  logic [4:0]                   i_shift,
  input  logic                         i_relu_en,
  input  logic                         i_psum_valid,
  input  logic signed [PSUM_WIDTH-1:0] i_psum,
  psum_requant_if.master               out,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err,
  output state_t                       o_state
);
  localparam int PROD_WIDTH = ACC_WIDTH + 17;
  localparam logic signed [PROD_WIDTH-1:0] OUT_MAX =
    {{(PROD_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [PROD_WIDTH-1:0] OUT_MIN =
    {{(PROD_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  state_t  state, state_nx;
  rq_cfg_t cfg;

  logic signed [ACC_WIDTH-1:0]  acc, psum_ext, sum;
  logic [7:0]                   chunk_cnt;
  logic [15:0]                  out_cnt;
  logic                         take, last_chunk, last_out, fwd, drop, start_ok;

  logic                         p1_valid, p1_last;
  logic signed [PROD_WIDTH-1:0] p1_prod;
  logic signed [PROD_WIDTH-1:0] rnd, rounded, shifted, clamped;
  logic                         p2_valid, p2_last;
  logic signed [OUT_WIDTH-1:0]  p2_data;

  logic                         fifo_ovf, fifo_empty, fifo_rd;
  logic [OUT_WIDTH:0]           fifo_rd_data;

  assign psum_ext   = ACC_WIDTH'(i_psum);
  assign sum        = acc + psum_ext;
  assign start_ok   = (state == ST_IDLE) && i_start;
  assign take       = (state == ST_ACCUM) && i_psum_valid;
  assign last_chunk = (chunk_cnt == cfg.num_chunks - 8'd1);
  assign last_out   = (out_cnt == cfg.num_outputs - 16'd1);
  assign fwd        = take && last_chunk;
  assign drop       = i_psum_valid && (state != ST_ACCUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    o_done   = 1'b0;
    case (state)
      ST_IDLE:  if (i_start) state_nx = ST_ACCUM;
      ST_ACCUM: if (fwd && last_out) state_nx = ST_DRAIN;
      ST_DRAIN: begin
        if (!p1_valid && !p2_valid && fifo_empty) begin
          state_nx = ST_IDLE;
          o_done   = 1'b1;
        end
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign o_busy  = (state != ST_IDLE);
  assign o_state = state;

  // Accumulator, counters and configuration; the final chunk bypasses acc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg       <= '0;
      acc       <= '0;
      chunk_cnt <= '0;
      out_cnt   <= '0;
    end else if (start_ok) begin
      cfg.num_chunks  <= 8'(at_least_one({8'd0, i_num_chunks}));
      cfg.num_outputs <= at_least_one(i_num_outputs);
      cfg.scale       <= i_scale;
      cfg.shift       <= i_shift;
      cfg.relu_en     <= i_relu_en;
      acc             <= '0;
      chunk_cnt       <= '0;
      out_cnt         <= '0;
    end else if (take) begin
      if (last_chunk) begin
        acc       <= '0;
        chunk_cnt <= '0;
        out_cnt   <= out_cnt + 16'd1;
      end else begin
        acc       <= sum;
        chunk_cnt <= chunk_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    rnd = '0;
    if (cfg.shift != 5'd0) rnd[cfg.shift - 5'd1] = 1'b1;
    rounded = p1_prod + rnd;
    shifted = rounded >>> cfg.shift;
    clamped = shifted;
    if (cfg.relu_en && shifted < 0) clamped = '0;
    if (clamped > OUT_MAX)      clamped = OUT_MAX;
    else if (clamped < OUT_MIN) clamped = OUT_MIN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid <= 1'b0;
      p1_last  <= 1'b0;
      p1_prod  <= '0;
      p2_valid <= 1'b0;
      p2_last  <= 1'b0;
      p2_data  <= '0;
      o_err    <= 1'b0;
    end else begin
      p1_valid <= fwd;
      p1_last  <= fwd && last_out;
      if (fwd) p1_prod <= PROD_WIDTH'(sum) * PROD_WIDTH'($signed({1'b0, cfg.scale}));
      p2_valid <= p1_valid;
      if (p1_valid) begin
        p2_last <= p1_last;
        p2_data <= clamped[OUT_WIDTH-1:0];
      end
      o_err <= (o_err && !start_ok) || drop || fifo_ovf;
    end
  end

  assign fifo_rd = out.o_valid && out.i_ready;

  psum_out_fifo #(
    .WIDTH (OUT_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (p2_valid),
    .wr_data ({p2_last, p2_data}),
    .ovf     (fifo_ovf),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty)
  );

  assign out.o_valid = !fifo_empty;
  assign out.o_last  = fifo_rd_data[OUT_WIDTH];
  assign out.o_data  = fifo_rd_data[OUT_WIDTH-1:0];

endmodule

// File: tb/tb_psum_requant.sv
// Directed bench for psum_requant: table of single-output jobs plus
// hand-written sequences for overflow, reset, ignored start and stray psums.
module tb_psum_requant;
  import psum_requant_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_start;
  logic [7:0]         i_num_chunks;
  logic [15:0]        i_num_outputs;
  logic [15:0]        i_scale;
  logic [4:0]         i_shift;
  logic               i_relu_en;
  logic               i_psum_valid;
  logic signed [31:0] i_psum;
  logic               o_busy, o_done, o_err;
  state_t             o_state;

  psum_requant_if #(.OUT_WIDTH(8)) out_if ();

  psum_requant #(
    .ACC_WIDTH  (40),
    .FIFO_DEPTH (4),
    .OUT_WIDTH  (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_num_chunks  (i_num_chunks),
    .i_num_outputs (i_num_outputs),
    .i_scale       (i_scale),
    .i_shift       (i_shift),
    .i_relu_en     (i_relu_en),
    .i_psum_valid  (i_psum_valid),
    .i_psum        (i_psum),
    .out           (out_if.master),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err),
    .o_state       (o_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int chunks;
    int scale;
    int shift;
    int relu;
    int psum[4];
    int exp_data;
  } vec_t;

  vec_t vecs[8];
  int   total = 0;
  int   bad   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic start_job(input int chunks, input int outputs, input int scale,
                           input int shift, input int relu);
    @(negedge clk);
    i_num_chunks  = 8'(chunks);
    i_num_outputs = 16'(outputs);
    i_scale       = 16'(scale);
    i_shift       = 5'(shift);
    i_relu_en     = relu[0];
    i_start       = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!o_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, o_done, 1);
    @(negedge clk);
    check({name, "_done_pulse"}, o_done, 0);
    check({name, "_idle"}, 32'(o_state), 32'(ST_IDLE));
    check({name, "_busy"}, o_busy, 0);
  endtask

  task automatic expect_pop(input string name, input int exp_data, input int exp_last);
    int n = 0;
    while (!out_if.o_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, out_if.o_valid, 1);
    check({name, "_data"}, $signed(out_if.o_data), exp_data);
    check({name, "_last"}, out_if.o_last, exp_last);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int n;
    n = (v.chunks == 0) ? 1 : v.chunks;
    start_job(v.chunks, 1, v.scale, v.shift, v.relu);
    for (int k = 0; k < n; k++) begin
      i_psum_valid = 1'b1;
      i_psum       = v.psum[k];
      @(negedge clk);
    end
    i_psum_valid = 1'b0;
    check({name, "_t1_valid"}, out_if.o_valid, 0);
    @(negedge clk);
    check({name, "_t2_valid"}, out_if.o_valid, 0);
    @(negedge clk);
    check({name, "_t3_valid"}, out_if.o_valid, 1);
    check({name, "_data"}, $signed(out_if.o_data), v.exp_data);
    check({name, "_last"}, out_if.o_last, 1);
    wait_done(name);
    check({name, "_err"}, o_err, 0);
  endtask

  initial begin
    vec_t v;
    int   xfers, n, seen;
    vecs[0] = '{chunks: 1, scale: 1, shift: 0, relu: 0, psum: '{100, 0, 0, 0},         exp_data: 100};
    vecs[1] = '{chunks: 4, scale: 5, shift: 3, relu: 0, psum: '{10, 20, 30, 40},       exp_data: 63};
    vecs[2] = '{chunks: 4, scale: 5, shift: 3, relu: 0, psum: '{1000, 2000, -500, 300}, exp_data: 127};
    vecs[3] = '{chunks: 1, scale: 1, shift: 3, relu: 0, psum: '{-100, 0, 0, 0},        exp_data: -12};
    vecs[4] = '{chunks: 1, scale: 1, shift: 3, relu: 1, psum: '{-100, 0, 0, 0},        exp_data: 0};
    vecs[5] = '{chunks: 1, scale: 1, shift: 0, relu: 0, psum: '{-5000, 0, 0, 0},       exp_data: -128};
    vecs[6] = '{chunks: 0, scale: 2, shift: 1, relu: 0, psum: '{7, 0, 0, 0},           exp_data: 7};
    vecs[7] = '{chunks: 2, scale: 3, shift: 2, relu: 1, psum: '{9, -3, 0, 0},          exp_data: 5};

    rst_n = 1'b0;
    i_start = 1'b0; i_num_chunks = '0; i_num_outputs = '0; i_scale = '0;
    i_shift = '0; i_relu_en = 1'b0; i_psum_valid = 1'b0; i_psum = '0;
    out_if.i_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", out_if.o_valid, 0);
    check("rst_data", $signed(out_if.o_data), 0);
    check("rst_last", out_if.o_last, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    check("rst_state", 32'(o_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // FIFO overflow: six outputs into four slots with the consumer stalled
    out_if.i_ready = 1'b0;
    start_job(1, 6, 1, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      i_psum_valid = 1'b1;
      i_psum       = k;
      @(negedge clk);
    end
    i_psum_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("ovf_err", o_err, 1);
    check("ovf_valid", out_if.o_valid, 1);
    check("ovf_state", 32'(o_state), 32'(ST_DRAIN));
    @(negedge clk);
    check("ovf_hold_data", $signed(out_if.o_data), 1);
    for (int k = 1; k <= 4; k++) exp_q.push_back(8'(k));
    out_if.i_ready = 1'b1;
    xfers = 0;
    n = 0;
    while (xfers < 4 && n < 20) begin
      if (out_if.o_valid) begin
        check($sformatf("ovf_pop%0d_data", xfers), $signed(out_if.o_data),
              $signed(exp_q.pop_front()));
        check($sformatf("ovf_pop%0d_last", xfers), out_if.o_last, 0);
        xfers++;
      end
      @(negedge clk);
      n++;
    end
    check("ovf_xfers", xfers, 4);
    check("ovf_no_extra", out_if.o_valid, 0);
    wait_done("ovf");
    check("ovf_err_sticky", o_err, 1);

    // stray partial sum while idle
    i_psum_valid = 1'b1;
    i_psum       = 55;
    @(negedge clk);
    i_psum_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_if.o_valid) seen = 1;
      @(negedge clk);
    end
    check("idle_psum_err", o_err, 1);
    check("idle_psum_no_out", seen, 0);
    check("idle_psum_state", 32'(o_state), 32'(ST_IDLE));

    // reset in the middle of a job
    start_job(4, 1, 1, 0, 0);
    check("start_clears_err", o_err, 0);
    i_psum_valid = 1'b1; i_psum = 50; @(negedge clk);
    i_psum = 50; @(negedge clk);
    i_psum_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_state", 32'(o_state), 32'(ST_IDLE));
    check("midrst_busy", o_busy, 0);
    check("midrst_valid", out_if.o_valid, 0);
    check("midrst_data", $signed(out_if.o_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v = '{chunks: 4, scale: 1, shift: 0, relu: 0, psum: '{1, 2, 3, 4}, exp_data: 10};
    run_vec(v, "post_rst");

    // start pulse during ACCUM must not change the running job's config
    start_job(2, 1, 1, 0, 0);
    i_psum_valid  = 1'b1;
    i_psum        = 7;
    i_start       = 1'b1;
    i_num_chunks  = 8'd1;
    i_scale       = 16'd3;
    @(negedge clk);
    i_start = 1'b0;
    i_psum  = 8;
    @(negedge clk);
    i_psum_valid = 1'b0;
    expect_pop("ign_start", 15, 1);
    wait_done("ign_start");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psum_requant.md
PSUM_REQUANT -- requirements
Module: psum_requant

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 40: partial-sum accumulator width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries (power of 2).
REQ-003 SHALL have parameter OUT_WIDTH, default 8: quantized output width.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_start  input  1  job start pulse; latches config; ignored unless IDLE.
REQ-007 i_num_chunks  input  8  partial sums per output; 0 treated as 1.
REQ-008 i_num_outputs  input  16  outputs per job; 0 treated as 1.
REQ-009 i_scale  input  16  unsigned requant multiplier.
REQ-010 i_shift  input  5  arithmetic right shift after multiply.
REQ-011 i_relu_en  input  1  clamp negative results to 0.
REQ-012 i_psum_valid  input  1  partial sum valid; no backpressure toward the dot-product core.
REQ-013 i_psum  input  32 signed  partial sum from the dot-product core.
REQ-014 o_valid / i_ready  output / input  1 / 1  downstream handshake; a transfer occurs when both are high.
REQ-015 o_data  output  OUT_WIDTH signed  quantized result.
REQ-016 o_last  output  1  high with the final output of a job.
REQ-017 o_busy  output  1  high when state is not IDLE.
REQ-018 o_done  output  1  one-cycle pulse on the DRAIN->IDLE transition.
REQ-019 o_err  output  1  sticky error flag; cleared by an accepted i_start.

Function
REQ-020 FSM states SHALL be IDLE, ACCUM, DRAIN.
- IDLE->ACCUM on i_start: latch config; clear accumulator, chunk counter and output counter.
REQ-021 In ACCUM, each i_psum_valid SHALL add sign-extended i_psum to the accumulator and increment the chunk counter.
REQ-022 On the final chunk, the module SHALL forward accumulator+i_psum to quant stage 1, clear the accumulator and chunk counter in the same cycle, and increment the output counter.
REQ-023 After the i_num_outputs-th output is forwarded, state SHALL go ACCUM->DRAIN.
- DRAIN->IDLE once the pipeline and FIFO are empty, with o_done pulsing for one cycle.
REQ-024 i_psum_valid in IDLE or DRAIN SHALL be dropped and set o_err.
REQ-025 Stage 1 SHALL register sum*scale as a full-precision signed product; scale is zero-extended.
REQ-026 Stage 2 SHALL add 2^(shift-1) when shift>0, shift right arithmetically, apply ReLU if enabled, saturate to [-128,127], and write the result to the FIFO.
REQ-027 Latency: for a final chunk in cycle T with the FIFO empty, o_valid SHALL be high in cycle T+3.
REQ-028 The FIFO SHALL be show-ahead; o_data and o_last SHALL be stable while o_valid is high and i_ready is low.
REQ-029 Writing to a full FIFO SHALL drop the entry and set o_err.
- Exception: a read in the same cycle as the write frees a slot, and the write succeeds.
REQ-030 Write and read in the same cycle on a non-full FIFO SHALL leave occupancy unchanged.
REQ-031 o_last SHALL travel through the pipeline and FIFO with its data word.

Reset
REQ-032 On rst_n low, the module SHALL immediately enter IDLE.
- Counters, accumulator, pipeline valids and FIFO pointers clear.
- o_valid=0, o_data=0, o_last=0, o_busy=0, o_done=0, o_err=0.
REQ-033 Reset mid-job SHALL discard all partial and queued results.

Structure
REQ-034 package_def SHALL hold the PSUM_WIDTH=32, ACC_WIDTH and OUT_WIDTH constants, the requant config struct, and the state enum.
REQ-035 The FIFO SHALL be a separate sub-module, psum_out_fifo, instantiated once.

Verification
REQ-036 Config chunks=1, scale=1, shift=0; psum 100 in cycle T -> o_data=100, o_valid at T+3, o_last=1, o_done pulses.
REQ-037 Config chunks=4, scale=5, shift=3; psums 10,20,30,40 -> o_data=63. Same config with psums 1000,2000,-500,300 -> 127 (saturated).
REQ-038 psum -100, scale 1, shift 3 -> -12 with relu off, 0 with relu on; psum -5000, shift 0 -> -128.
REQ-039 chunks=1, 6 outputs, i_ready=0, FIFO_DEPTH=4 -> 4 retained, 2 dropped, o_err=1; raising i_ready then yields 4 transfers in order.
REQ-040 rst_n low after 2 of 4 chunks -> all outputs at reset values, state IDLE; next job's result excludes the old partial sum.
REQ-041 i_start during ACCUM ignored (config unchanged); i_psum_valid in IDLE -> o_err=1 and no output.
